// File: rtl/ccsds_scrambler_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ccsds_scrambler_ctrl_if
//  Description : Symbol-stream handshake bundle for ccsds_scrambler_ctrl.
//                Input side: valid/ready, I/Q, frame markers.
//                Output side: valid/ready, I/Q, markers, header flag, rotation.
//  Revision    : 1.0  initial release
// ============================================================================
interface ccsds_scrambler_ctrl_if #(
    parameter int IQ_W = 8
);
    // upstream -> block
    logic            i_valid;
    logic            o_ready;
    logic [IQ_W-1:0] i_i;
    logic [IQ_W-1:0] i_q;
    logic            i_sof;
    logic            i_eof;
    // block -> downstream
    logic            o_valid;
    logic            i_ready;
    logic [IQ_W-1:0] o_i;
    logic [IQ_W-1:0] o_q;
    logic            o_sof;
    logic            o_eof;
    logic            o_hdr;
    logic [1:0]      o_rot;

    // the scrambler controller itself
    modport slave (
        input  i_valid, i_i, i_q, i_sof, i_eof, i_ready,
        output o_ready, o_valid, o_i, o_q, o_sof, o_eof, o_hdr, o_rot
    );

    // the environment that feeds and drains the controller
    modport master (
        output i_valid, i_i, i_q, i_sof, i_eof, i_ready,
        input  o_ready, o_valid, o_i, o_q, o_sof, o_eof, o_hdr, o_rot
    );
endinterface
`default_nettype wire

// File: rtl/ccsds_scrambler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ccsds_scrambler_ctrl
//  Description : Frame sequencer for the CCSDS Gold-sequence randomizer.
//                Header symbols pass through untouched; each data symbol is
//                rotated by j^R using one randomizer step. Single output
//                register with full-throughput valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module ccsds_scrambler_ctrl #(
    parameter int IQ_W     = 8,
    parameter int HDR_LEN  = 2,
    parameter int MAX_DATA = 262142
) (
    input  wire logic               i_clk,
    input  wire logic               i_reset,
    ccsds_scrambler_ctrl_if.slave   bus,
    output logic                    o_rand_reset,
    output logic                    o_rand_en,
    input  wire logic [1:0]         i_rand_r,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam logic [IQ_W-1:0] c_MIN      = {1'b1, {(IQ_W-1){1'b0}}};
    localparam logic [IQ_W-1:0] c_MAX      = {1'b0, {(IQ_W-1){1'b1}}};
    localparam logic [IQ_W-1:0] c_ONE      = {{(IQ_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]      c_HDR_LAST = 8'(HDR_LEN - 1);
    localparam logic [17:0]     c_DAT_LAST = 18'(MAX_DATA - 1);
    localparam bit              c_HDR_ONE  = (HDR_LEN == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_hdr_cnt;
    logic [17:0]     r_data_cnt;
    logic            r_err;
    logic            r_valid;
    logic [IQ_W-1:0] r_i;
    logic [IQ_W-1:0] r_q;
    logic            r_sof;
    logic            r_eof;
    logic            r_hdr;
    logic [1:0]      r_rot;

    state_t          w_state_nxt;
    logic [7:0]      w_hdr_cnt_nxt;
    logic [17:0]     w_data_cnt_nxt;
    logic            w_err_nxt;
    logic            w_load;
    logic [IQ_W-1:0] w_i_nxt;
    logic [IQ_W-1:0] w_q_nxt;
    logic            w_sof_nxt;
    logic            w_eof_nxt;
    logic            w_hdr_nxt;
    logic [1:0]      w_rot_nxt;
    logic            w_ready;
    logic            w_in_fire;
    logic            w_out_fire;

    // Two's-complement negation clamped so the most negative code maps to max.
    function automatic logic [IQ_W-1:0] sat_neg(input logic [IQ_W-1:0] x);
        return (x == c_MIN) ? c_MAX : ((~x) + c_ONE);
    endfunction

    // Handshake: ready whenever the output register is empty or draining,
    // and never while reset is asserted so nothing fires during reset.
    always_comb begin
        w_ready    = !i_reset && (!r_valid || bus.i_ready);
        w_in_fire  = bus.i_valid && w_ready;
        w_out_fire = r_valid && bus.i_ready;
    end

    // Next-state, counters, error flag and next output-register contents.
    always_comb begin
        w_state_nxt    = r_state;
        w_hdr_cnt_nxt  = r_hdr_cnt;
        w_data_cnt_nxt = r_data_cnt;
        w_err_nxt      = r_err;
        w_load         = 1'b0;
        w_i_nxt        = bus.i_i;
        w_q_nxt        = bus.i_q;
        w_sof_nxt      = 1'b0;
        w_eof_nxt      = 1'b0;
        w_hdr_nxt      = 1'b0;
        w_rot_nxt      = 2'd0;

        if (w_in_fire) begin
            if (bus.i_sof) begin
                // A start-of-frame always restarts the frame, even mid-frame.
                w_load         = 1'b1;
                w_sof_nxt      = 1'b1;
                w_hdr_nxt      = 1'b1;
                w_hdr_cnt_nxt  = 8'd1;
                w_data_cnt_nxt = 18'd0;
                w_state_nxt    = c_HDR_ONE ? ST_DATA : ST_HDR;
                if (r_state != ST_IDLE) begin
                    w_err_nxt = 1'b1;
                end
                if (bus.i_eof) begin
                    w_err_nxt   = 1'b1;
                    w_eof_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Orphan symbol outside a frame: drop it.
                        w_err_nxt = 1'b1;
                    end
                    ST_HDR: begin
                        w_load        = 1'b1;
                        w_hdr_nxt     = 1'b1;
                        w_hdr_cnt_nxt = r_hdr_cnt + 8'd1;
                        if (r_hdr_cnt == c_HDR_LAST) begin
                            w_state_nxt = ST_DATA;
                        end
                        if (bus.i_eof) begin
                            w_eof_nxt   = 1'b1;
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        w_load         = 1'b1;
                        w_rot_nxt      = i_rand_r;
                        w_data_cnt_nxt = r_data_cnt + 18'd1;
                        case (i_rand_r)
                            2'd0: begin w_i_nxt = bus.i_i;          w_q_nxt = bus.i_q;          end
                            2'd1: begin w_i_nxt = sat_neg(bus.i_q); w_q_nxt = bus.i_i;          end
                            2'd2: begin w_i_nxt = sat_neg(bus.i_i); w_q_nxt = sat_neg(bus.i_q); end
                            default: begin w_i_nxt = bus.i_q;       w_q_nxt = sat_neg(bus.i_i); end
                        endcase
                        if (bus.i_eof) begin
                            w_eof_nxt      = 1'b1;
                            w_state_nxt    = ST_IDLE;
                            w_data_cnt_nxt = 18'd0;
                        end else if (r_data_cnt == c_DAT_LAST) begin
                            // Frame overran the data limit: close it ourselves.
                            w_eof_nxt      = 1'b1;
                            w_err_nxt      = 1'b1;
                            w_state_nxt    = ST_IDLE;
                            w_data_cnt_nxt = 18'd0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State, counters, sticky error and the single output register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_hdr_cnt  <= 8'd0;
            r_data_cnt <= 18'd0;
            r_err      <= 1'b0;
            r_valid    <= 1'b0;
            r_i        <= '0;
            r_q        <= '0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_hdr      <= 1'b0;
            r_rot      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hdr_cnt  <= w_hdr_cnt_nxt;
            r_data_cnt <= w_data_cnt_nxt;
            r_err      <= w_err_nxt;
            if (w_load) begin
                r_valid <= 1'b1;
                r_i     <= w_i_nxt;
                r_q     <= w_q_nxt;
                r_sof   <= w_sof_nxt;
                r_eof   <= w_eof_nxt;
                r_hdr   <= w_hdr_nxt;
                r_rot   <= w_rot_nxt;
            end else if (w_out_fire) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Randomizer sees a restart on every accepted sof and one step per
    // accepted data symbol; R is sampled before that step takes effect.
    assign o_rand_reset = w_in_fire && bus.i_sof;
    assign o_rand_en    = w_in_fire && !bus.i_sof && (r_state == ST_DATA);

    assign bus.o_ready = w_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_i     = r_i;
    assign bus.o_q     = r_q;
    assign bus.o_sof   = r_sof;
    assign bus.o_eof   = r_eof;
    assign bus.o_hdr   = r_hdr;
    assign bus.o_rot   = r_rot;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ccsds_scrambler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccsds_scrambler_ctrl
//  Description : Directed self-checking bench for ccsds_scrambler_ctrl.
//                A second instance with MAX_DATA=3 shares the same stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ccsds_scrambler_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ccsds_scrambler_ctrl_if #(.IQ_W(8)) b1 ();
    ccsds_scrambler_ctrl_if #(.IQ_W(8)) b2 ();

    logic       rr1, en1, busy1, err1;
    logic       rr2, en2, busy2, err2;
    logic [1:0] stub_r  = 2'd0;
    logic [1:0] model_r = 2'd0;
    logic [1:0] rand_r;
    bit         use_model = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rr    = 0;
    int n_en    = 0;
    logic obs_rr, obs_en;

    assign rand_r = use_model ? model_r : stub_r;

    // Stand-in randomizer: R=0 after restart, advancing by one each step.
    always @(posedge clk) begin
        if (rr1)      model_r <= 2'd0;
        else if (en1) model_r <= model_r + 2'd1;
    end

    assign b2.i_valid = b1.i_valid;
    assign b2.i_i     = b1.i_i;
    assign b2.i_q     = b1.i_q;
    assign b2.i_sof   = b1.i_sof;
    assign b2.i_eof   = b1.i_eof;
    assign b2.i_ready = b1.i_ready;

    ccsds_scrambler_ctrl #(.IQ_W(8), .HDR_LEN(2), .MAX_DATA(262142)) dut (
        .i_clk(clk), .i_reset(rst), .bus(b1.slave),
        .o_rand_reset(rr1), .o_rand_en(en1), .i_rand_r(rand_r),
        .o_busy(busy1), .o_err(err1)
    );

    ccsds_scrambler_ctrl #(.IQ_W(8), .HDR_LEN(2), .MAX_DATA(3)) dut_max (
        .i_clk(clk), .i_reset(rst), .bus(b2.slave),
        .o_rand_reset(rr2), .o_rand_en(en2), .i_rand_r(rand_r),
        .o_busy(busy2), .o_err(err2)
    );

    // {valid, I, Q, sof, eof, hdr, rot}
    function automatic logic [21:0] out1();
        return {b1.o_valid, b1.o_i, b1.o_q, b1.o_sof, b1.o_eof, b1.o_hdr, b1.o_rot};
    endfunction

    function automatic logic [21:0] ex(bit v, int i, int q, bit s, bit e, bit h, logic [1:0] r);
        return {v, 8'(i), 8'(q), s, e, h, r};
    endfunction

    // Present one symbol for one cycle (downstream assumed ready).
    task automatic send(input int i, input int q, input bit sof, input bit eof, input logic [1:0] r);
        b1.i_valid = 1'b1;
        b1.i_i     = 8'(i);
        b1.i_q     = 8'(q);
        b1.i_sof   = sof;
        b1.i_eof   = eof;
        stub_r     = r;
        #4;
        obs_rr = rr1;
        obs_en = en1;
        n_rr  += int'(rr1);
        n_en  += int'(en1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        b1.i_valid = 1'b0;
        b1.i_sof   = 1'b0;
        b1.i_eof   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b1.i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b1.i_valid = 1'b1;
        b1.i_sof   = 1'b1;
        #4;
        n_tests++;
        if ({b1.o_ready, rr1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b exp 00", {b1.o_ready, rr1});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        b1.i_valid = 1'b0;
        b1.i_sof   = 1'b0;
        n_tests++;
        if ({out1(), busy1, err1} !== 24'd0) begin
            n_fail++; $display("FAIL reset_state: got %h exp 0", {out1(), busy1, err1});
        end
    endtask

    task automatic test_frame();
        logic [21:0] e;
        use_model = 1'b1;
        n_rr = 0; n_en = 0;
        send(1, 1, 1, 0, 2'd0);
        e = ex(1, 1, 1, 1, 0, 1, 2'd0);
        n_tests++;
        if ({out1(), obs_rr, busy1} !== {e, 2'b11}) begin
            n_fail++; $display("FAIL frame_sof: got %h exp %h", {out1(), obs_rr, busy1}, {e, 2'b11});
        end
        send(2, 2, 0, 0, 2'd0);
        e = ex(1, 2, 2, 0, 0, 1, 2'd0);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL frame_hdr: got %h exp %h", out1(), e); end
        send(5, -3, 0, 0, 2'd0);
        e = ex(1, 5, -3, 0, 0, 0, 2'd0);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL frame_data0: got %h exp %h", out1(), e); end
        send(5, -3, 0, 0, 2'd0);
        e = ex(1, 3, 5, 0, 0, 0, 2'd1);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL frame_data1: got %h exp %h", out1(), e); end
        send(5, -3, 0, 1, 2'd0);
        e = ex(1, -5, 3, 0, 1, 0, 2'd2);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL frame_data2: got %h exp %h", out1(), e); end
        idle();
        n_tests++;
        if (n_rr !== 1 || n_en !== 3) begin
            n_fail++; $display("FAIL frame_pulses: got rr=%0d en=%0d exp rr=1 en=3", n_rr, n_en);
        end
        n_tests++;
        if ({b1.o_valid, busy1, err1} !== 3'b000) begin
            n_fail++; $display("FAIL frame_end: got %b exp 000", {b1.o_valid, busy1, err1});
        end
    endtask

    task automatic test_rotation();
        logic [21:0] e;
        use_model = 1'b0;
        send(0, 0, 1, 0, 2'd0);
        send(0, 0, 0, 0, 2'd0);
        send(5, -3, 0, 0, 2'd1);
        e = ex(1, 3, 5, 0, 0, 0, 2'd1);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL rot_r1: got %h exp %h", out1(), e); end
        send(5, -3, 0, 0, 2'd2);
        e = ex(1, -5, 3, 0, 0, 0, 2'd2);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL rot_r2: got %h exp %h", out1(), e); end
        send(5, -3, 0, 0, 2'd3);
        e = ex(1, -3, -5, 0, 0, 0, 2'd3);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL rot_r3: got %h exp %h", out1(), e); end
        send(-128, -128, 0, 0, 2'd2);
        e = ex(1, 127, 127, 0, 0, 0, 2'd2);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL sat_r2: got %h exp %h", out1(), e); end
        send(-128, 5, 0, 0, 2'd1);
        e = ex(1, -5, -128, 0, 0, 0, 2'd1);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL neg_r1: got %h exp %h", out1(), e); end
        send(7, -128, 0, 1, 2'd3);
        e = ex(1, -128, -7, 0, 1, 0, 2'd3);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL neg_r3: got %h exp %h", out1(), e); end
        idle();
    endtask

    task automatic test_stall();
        logic [21:0] e;
        use_model = 1'b0;
        send(0, 0, 1, 0, 2'd0);
        send(0, 0, 0, 0, 2'd0);
        send(10, 20, 0, 0, 2'd0);
        b1.i_ready = 1'b0;
        b1.i_i     = 8'(30);
        b1.i_q     = 8'(40);
        stub_r     = 2'd1;
        e = ex(1, 10, 20, 0, 0, 0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            #4;
            n_tests++;
            if ({b1.o_ready, en1, out1()} !== {2'b00, e}) begin
                n_fail++; $display("FAIL stall_hold%0d: got %h exp %h", k, {b1.o_ready, en1, out1()}, {2'b00, e});
            end
            @(posedge clk); #1;
        end
        b1.i_ready = 1'b1;
        #4;
        n_tests++;
        if ({b1.o_ready, en1} !== 2'b11) begin
            n_fail++; $display("FAIL stall_release: got %b exp 11", {b1.o_ready, en1});
        end
        @(posedge clk); #1;
        e = ex(1, -40, 30, 0, 0, 0, 2'd1);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL stall_next: got %h exp %h", out1(), e); end
        send(50, 60, 0, 1, 2'd0);
        e = ex(1, 50, 60, 0, 1, 0, 2'd0);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL stall_last: got %h exp %h", out1(), e); end
        idle();
        n_tests++;
        if ({b1.o_valid, busy1, err1} !== 3'b000) begin
            n_fail++; $display("FAIL stall_end: got %b exp 000", {b1.o_valid, busy1, err1});
        end
    endtask

    task automatic test_errors();
        logic [21:0] e;
        use_model = 1'b0;
        do_reset();
        send(9, 9, 0, 0, 2'd0);
        n_tests++;
        if ({b1.o_valid, busy1, err1} !== 3'b001) begin
            n_fail++; $display("FAIL idle_drop: got %b exp 001", {b1.o_valid, busy1, err1});
        end
        do_reset();
        n_tests++;
        if (err1 !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b exp 0", err1); end
        send(0, 0, 1, 0, 2'd0);
        send(0, 0, 0, 0, 2'd0);
        send(1, 2, 0, 0, 2'd0);
        send(3, 4, 1, 0, 2'd0);
        e = ex(1, 3, 4, 1, 0, 1, 2'd0);
        n_tests++;
        if ({out1(), obs_rr, busy1, err1} !== {e, 3'b111}) begin
            n_fail++; $display("FAIL sof_in_data: got %h exp %h", {out1(), obs_rr, busy1, err1}, {e, 3'b111});
        end
        idle();
    endtask

    task automatic test_max_data();
        use_model = 1'b0;
        do_reset();
        send(0, 0, 1, 0, 2'd0);
        send(0, 0, 0, 0, 2'd0);
        send(1, 1, 0, 0, 2'd0);
        send(2, 2, 0, 0, 2'd0);
        n_tests++;
        if ({b2.o_valid, b2.o_eof, err2, busy2} !== 4'b1001) begin
            n_fail++; $display("FAIL max_second: got %b exp 1001", {b2.o_valid, b2.o_eof, err2, busy2});
        end
        send(3, 3, 0, 0, 2'd0);
        n_tests++;
        if ({b2.o_valid, b2.o_i, b2.o_eof, err2, busy2} !== {1'b1, 8'd3, 3'b110}) begin
            n_fail++; $display("FAIL max_third: got %h exp %h", {b2.o_valid, b2.o_i, b2.o_eof, err2, busy2}, {1'b1, 8'd3, 3'b110});
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [21:0] e;
        use_model = 1'b1;
        do_reset();
        send(1, 1, 1, 0, 2'd0);
        send(2, 2, 0, 0, 2'd0);
        send(5, -3, 0, 0, 2'd0);
        send(5, -3, 0, 0, 2'd0);
        rst = 1'b1;
        b1.i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if ({b1.o_valid, busy1, err1} !== 3'b000) begin
            n_fail++; $display("FAIL midreset: got %b exp 000", {b1.o_valid, busy1, err1});
        end
        send(1, 1, 1, 0, 2'd0);
        send(2, 2, 0, 0, 2'd0);
        send(5, -3, 0, 0, 2'd0);
        e = ex(1, 5, -3, 0, 0, 0, 2'd0);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL midreset_first: got %h exp %h", out1(), e); end
        send(5, -3, 0, 1, 2'd0);
        e = ex(1, 3, 5, 0, 1, 0, 2'd1);
        n_tests++;
        if (out1() !== e) begin n_fail++; $display("FAIL midreset_second: got %h exp %h", out1(), e); end
        idle();
        n_tests++;
        if ({busy1, err1} !== 2'b00) begin
            n_fail++; $display("FAIL midreset_end: got %b exp 00", {busy1, err1});
        end
    endtask

    initial begin
        b1.i_valid = 1'b0;
        b1.i_i     = '0;
        b1.i_q     = '0;
        b1.i_sof   = 1'b0;
        b1.i_eof   = 1'b0;
        b1.i_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_frame();
        test_rotation();
        test_stall();
        test_errors();
        test_max_data();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
